// File: rtl/matrix_link_pkg.sv
// Shared definitions for the HPS <-> matrix coprocessor link controller.
// Latency: n/a (types, field positions and helpers only).
// Backpressure: n/a.
package matrix_link_pkg;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECV     = 3'd1,
    S_LAUNCH   = 3'd2,
    S_WAIT_COP = 3'd3,
    S_SEND     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  // data_in control fields (command word)
  localparam int READY_BIT = 31;
  localparam int START_BIT = 30;
  localparam int ABORT_BIT = 29;
  localparam int SIZE_LSB  = 19;  // 2-bit size code at [20:19]
  localparam int OPC_LSB   = 16;  // 3-bit opcode at [18:16]

  // data_out status fields
  localparam int ACK_BIT   = 31;
  localparam int BUSY_BIT  = 30;
  localparam int ERR_BIT   = 29;
  localparam int TMO_BIT   = 28;
  localparam int PAYLOAD_W = 24;  // result payload at [23:0]

  // Size code 0..3 selects a 2x2 .. 5x5 matrix.
  function automatic logic [2:0] size_to_dim(input logic [1:0] size_code);
    return {1'b0, size_code} + 3'd2;
  endfunction

endpackage

// File: rtl/hps_edge_sync.sv
// Two-flop synchroniser for the HPS ready handshake with a history flop for edge detect.
// Latency: level 2 cycles after the async input; rise pulse valid the same cycle as level.
// Backpressure: none; every synchronised rising edge yields exactly one single-cycle pulse.
// Ports: clk/reset (async, active-high), async_in (unsynchronised ready),
//        level (synchronised ready), rise (one-cycle pulse on synced rising edge).
module hps_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;

endmodule

// File: rtl/matrix_link_ctrl.sv
// HPS word link that loads operand matrices, launches the coprocessor and streams results back.
// Latency: one word per synced ready edge; result word 0 shows one cycle after entering SEND.
// Backpressure: HPS paces every transfer with ready edges; a watchdog bounds the coprocessor wait.
// Ports: clk, reset (async, active-high); data_in/data_out HPS words (control + operand/result
//        payload); cop_start/cop_opcode/cop_size/op_flat drive the coprocessor; res_flat and
//        cop_done return its result.
module matrix_link_ctrl
  import matrix_link_pkg::*;
#(
  parameter int ELEM_W      = 8,
  parameter int MAX_DIM     = 5,
  parameter int N_OPS       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [31:0]                            data_in,
  output logic [31:0]                            data_out,
  output logic                                   cop_start,
  output logic [2:0]                             cop_opcode,
  output logic [1:0]                             cop_size,
  output logic [N_OPS*MAX_DIM*MAX_DIM*ELEM_W-1:0] op_flat,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]       res_flat,
  input  logic                                   cop_done
);

  localparam int NE   = MAX_DIM * MAX_DIM;
  localparam int PACK = PAYLOAD_W / ELEM_W;
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_t                          state_q, state_d;
  logic [2:0]                      dim_q, dim_d;
  logic [2:0]                      row_q, row_d;
  logic [2:0]                      col_q, col_d;
  logic [5:0]                      word_q, word_d;
  logic [WD_W-1:0]                 wdog_q, wdog_d;
  logic                            err_q, err_d;
  logic                            tmo_q, tmo_d;
  logic [2:0]                      opc_q;
  logic [1:0]                      size_q;
  logic [N_OPS*NE*ELEM_W-1:0]      op_q;
  logic [NE*ELEM_W-1:0]            res_buf_q;
  logic [NE*ELEM_W-1:0]            res_compact;
  logic [PAYLOAD_W-1:0]            payload_d;
  logic                            load_cmd;
  logic                            wr_ops;
  logic                            cap_res;
  logic                            ack_d;
  logic                            busy_d;
  logic                            rdy_lvl;
  logic                            rdy_edge;
  logic                            start_in;
  logic                            abort_in;
  logic [5:0]                      last_word;
  int                              n_elems;

  // Bits of data_in that only matter in some word types.
  logic unused_bits;
  assign unused_bits = ^data_in;

  assign start_in = data_in[START_BIT];
  assign abort_in = data_in[ABORT_BIT];

  hps_edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (data_in[READY_BIT]),
    .level    (rdy_lvl),
    .rise     (rdy_edge)
  );

  // Number of live result elements and the index of the final SEND word.
  always_comb begin
    n_elems   = int'(dim_q) * int'(dim_q);
    last_word = 6'((n_elems + PACK - 1) / PACK - 1);
  end

  // ---------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dim_d    = dim_q;
    row_d    = row_q;
    col_d    = col_q;
    word_d   = word_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    load_cmd = 1'b0;
    wr_ops   = 1'b0;
    cap_res  = 1'b0;

    if (abort_in) begin
      // Abort wins over start and ready edges; partial work is dropped.
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      word_d  = '0;
      wdog_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start_in) begin
            load_cmd = 1'b1;
            dim_d    = size_to_dim(data_in[SIZE_LSB +: 2]);
            err_d    = 1'b0;
            tmo_d    = 1'b0;
            row_d    = '0;
            col_d    = '0;
            word_d   = '0;
            if (int'(dim_d) > MAX_DIM) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else begin
              state_d = S_RECV;
            end
          end
        end

        S_RECV: begin
          if (rdy_edge) begin
            wr_ops = 1'b1;
            if (col_q == dim_q - 3'd1) begin
              col_d = '0;
              if (row_q == dim_q - 3'd1) begin
                row_d   = '0;
                state_d = S_LAUNCH;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end

        S_LAUNCH: begin
          wdog_d  = '0;
          state_d = S_WAIT_COP;
        end

        S_WAIT_COP: begin
          if (cop_done) begin
            cap_res = 1'b1;
            word_d  = '0;
            state_d = S_SEND;
          end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end

        S_SEND: begin
          if (rdy_edge) begin
            if (word_q == last_word) begin
              word_d  = '0;
              state_d = S_IDLE;
            end else begin
              word_d = word_q + 6'd1;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Result compaction: the coprocessor returns a MAX_DIM-stride buffer;
  // SEND streams dim x dim elements back to back, so repack at capture.
  // ---------------------------------------------------------------------
  always_comb begin
    res_compact = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if ((r < int'(dim_q)) && (c < int'(dim_q)) &&
            ((r * int'(dim_q) + c) < NE)) begin
          res_compact[(r * int'(dim_q) + c) * ELEM_W +: ELEM_W] =
            res_flat[(r * MAX_DIM + c) * ELEM_W +: ELEM_W];
        end
      end
    end
  end

  // Payload for the current SEND word; trailing slots past the last element stay zero.
  always_comb begin
    payload_d = '0;
    if (state_q == S_SEND) begin
      for (int j = 0; j < PACK; j++) begin
        if ((int'(word_q) * PACK + j) < n_elems) begin
          payload_d[j * ELEM_W +: ELEM_W] =
            res_buf_q[(int'(word_q) * PACK + j) * ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign ack_d  = ((state_q == S_RECV) || (state_q == S_SEND)) && rdy_lvl;
  assign busy_d = !((state_d == S_IDLE) || (state_d == S_ERROR));

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dim_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      word_q    <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      opc_q     <= '0;
      size_q    <= '0;
      op_q      <= '0;
      res_buf_q <= '0;
      data_out  <= '0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      row_q   <= row_d;
      col_q   <= col_d;
      word_q  <= word_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;

      if (load_cmd) begin
        opc_q  <= data_in[OPC_LSB +: 3];
        size_q <= data_in[SIZE_LSB +: 2];
        // Positions outside the new dim x dim window must read zero.
        op_q   <= '0;
      end else if (wr_ops) begin
        for (int k = 0; k < N_OPS; k++) begin
          op_q[((k * NE) + int'(row_q) * MAX_DIM + int'(col_q)) * ELEM_W +: ELEM_W]
            <= data_in[k * ELEM_W +: ELEM_W];
        end
      end

      if (cap_res) begin
        res_buf_q <= res_compact;
      end

      data_out <= {ack_d, busy_d, err_d, tmo_d, 4'b0000, payload_d};
    end
  end

  // Launch pulse is suppressed if an abort lands in the LAUNCH cycle.
  assign cop_start  = (state_q == S_LAUNCH) && !abort_in;
  assign cop_opcode = opc_q;
  assign cop_size   = size_q;
  assign op_flat    = op_q;

endmodule

// File: tb/tb_matrix_link_ctrl.sv
module tb_matrix_link_ctrl;
  import matrix_link_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [31:0]  data_in, data_in4;
  logic [31:0]  data_out, data_out4;
  logic         cop_start, cop_start4;
  logic [2:0]   cop_opcode, cop_opcode4;
  logic [1:0]   cop_size, cop_size4;
  logic [599:0] op_flat;
  logic [383:0] op_flat4;
  logic [199:0] res_flat;
  logic [127:0] res_flat4;
  logic         cop_done, cop_done4;

  matrix_link_ctrl u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
    .cop_start(cop_start), .cop_opcode(cop_opcode), .cop_size(cop_size),
    .op_flat(op_flat), .res_flat(res_flat), .cop_done(cop_done)
  );

  matrix_link_ctrl #(.MAX_DIM(4)) u_dut4 (
    .clk(clk), .reset(reset), .data_in(data_in4), .data_out(data_out4),
    .cop_start(cop_start4), .cop_opcode(cop_opcode4), .cop_size(cop_size4),
    .op_flat(op_flat4), .res_flat(res_flat4), .cop_done(cop_done4)
  );

  int           vecs = 0;
  int           errs = 0;
  int           cs_cnt = 0;
  int           cs_cnt4 = 0;
  logic         tgt4 = 1'b0;
  logic [23:0]  exp_q[$];
  logic [599:0] exp_op;
  logic [7:0]   res_e[25];
  wire  [31:0]  dsel = tgt4 ? data_out4 : data_out;

  always @(negedge clk) begin
    if (cop_start === 1'b1) cs_cnt++;
    if (cop_start4 === 1'b1) cs_cnt4++;
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] v);
    if (tgt4) data_in4 = v;
    else      data_in  = v;
  endtask

  task automatic start_cmd(input int size, input int opc);
    drv(32'h4000_0000 | (32'(size) << 19) | (32'(opc) << 16));
    tick();
    drv(32'h0);
    tick();
    exp_op = '0;
  endtask

  task automatic xfer(input logic [31:0] v, input bit ack_chk);
    drv(v);
    tick();
    drv(v | 32'h8000_0000);
    repeat (4) tick();
    if (ack_chk) chk("ack_recv", dsel[31], 1'b1);
    drv(v);
    repeat (3) tick();
  endtask

  // mode 0: A=i, B=2i, C=0; otherwise seeded distinct bytes per operand
  task automatic load(input int dim, input int md, input int n, input int mode, input int seed);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a, b, c;
      int e;
      if (mode == 0) begin
        a = 8'(i); b = 8'(2 * i); c = 8'h00;
      end else begin
        a = 8'(seed + i); b = 8'(seed + 40 + i); c = 8'(seed + 80 + i);
      end
      xfer({8'h00, c, b, a}, i == 0);
      if (md == 5) begin
        e = (i / dim) * 5 + (i % dim);
        exp_op[e * 8 +: 8]        = a;
        exp_op[(25 + e) * 8 +: 8] = b;
        exp_op[(50 + e) * 8 +: 8] = c;
      end
    end
  endtask

  // Drive a result, push expected row-major payload words, pulse cop_done.
  task automatic fill_done(input int dim, input int md, input int base);
    logic [23:0] w;
    for (int e = 0; e < md * md; e++) begin
      res_e[e] = 8'(base + 7 * e);
      if (md == 5) res_flat[e * 8 +: 8] = res_e[e];
      else         res_flat4[e * 8 +: 8] = res_e[e];
    end
    for (int wi = 0; wi < (dim * dim + 2) / 3; wi++) begin
      w = '0;
      for (int j = 0; j < 3; j++) begin
        int ii;
        ii = wi * 3 + j;
        if (ii < dim * dim) w[j * 8 +: 8] = res_e[(ii / dim) * md + (ii % dim)];
      end
      exp_q.push_back(w);
    end
    if (tgt4) cop_done4 = 1'b1;
    else      cop_done  = 1'b1;
    tick();
    cop_done  = 1'b0;
    cop_done4 = 1'b0;
    tick();
  endtask

  task automatic drain();
    logic [23:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("payload", dsel[23:0], w);
      chk("busy_send", dsel[30], 1'b1);
      drv(32'h8000_0000);
      repeat (4) tick();
      drv(32'h0);
      repeat (3) tick();
    end
    chk("busy_end", dsel[30], 1'b0);
    chk("payload_end", dsel[23:0], 24'h0);
  endtask

  initial begin
    int          n;
    logic        acc;
    logic [23:0] w0;

    reset = 1'b1;
    data_in = '0; data_in4 = '0;
    res_flat = '0; res_flat4 = '0;
    cop_done = 1'b0; cop_done4 = 1'b0;
    repeat (3) tick();
    chk("rst_dout", data_out, 32'h0);
    chk("rst_cop_start", cop_start, 1'b0);
    chk("rst_op_flat", op_flat, '0);
    chk("rst_opc_size", {cop_opcode, cop_size}, 5'h0);
    reset = 1'b0;
    tick();

    // 5x5, opcode 1
    start_cmd(3, 1);
    chk("busy_recv", data_out[30], 1'b1);
    chk("opcode", cop_opcode, 3'd1);
    chk("size", cop_size, 2'd3);
    load(5, 5, 25, 0, 0);
    repeat (3) tick();
    chk("op_5x5", op_flat, exp_op);
    chk("cs_5x5", cs_cnt, 1);
    fill_done(5, 5, 100);
    drain();

    // 2x2
    start_cmd(0, 2);
    load(2, 5, 4, 1, 10);
    repeat (3) tick();
    chk("op_2x2", op_flat, exp_op);
    chk("cs_2x2", cs_cnt, 2);
    fill_done(2, 5, 3);
    drain();

    // watchdog timeout
    start_cmd(0, 3);
    load(2, 5, 4, 1, 20);
    n = 0;
    while (data_out[29] !== 1'b1 && n < 1200) begin
      tick();
      n++;
    end
    chk("tmo_err", data_out[29], 1'b1);
    chk("tmo_flag", data_out[28], 1'b1);
    chk("tmo_busy", data_out[30], 1'b0);
    chk("tmo_window", (n >= 1019 && n <= 1023), 1'b1);

    // start out of ERROR, abort after 10 words, fresh 3x3
    start_cmd(3, 4);
    chk("err_cleared", data_out[29:28], 2'b00);
    load(5, 5, 10, 1, 30);
    drv(32'h2000_0000);
    tick();
    chk("abort_busy", data_out[30], 1'b0);
    drv(32'h0);
    repeat (3) tick();
    chk("abort_no_cs", cs_cnt, 3);
    start_cmd(1, 5);
    load(3, 5, 9, 1, 60);
    repeat (3) tick();
    chk("op_3x3", op_flat, exp_op);
    chk("cs_3x3", cs_cnt, 4);
    fill_done(3, 5, 9);
    drain();

    // reset in the middle of SEND
    start_cmd(0, 6);
    load(2, 5, 4, 1, 90);
    fill_done(2, 5, 40);
    w0 = exp_q.pop_front();
    chk("send_w0", data_out[23:0], w0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_dout", data_out, 32'h0);
    chk("rst_mid_state", u_dut.state_q, S_IDLE);
    chk("rst_mid_size", cop_size, 2'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    acc = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drv(32'h8000_0000);
      repeat (5) begin tick(); acc = acc | data_out[31]; end
      drv(32'h0);
      repeat (3) begin tick(); acc = acc | data_out[31]; end
    end
    chk("no_ack_idle", acc, 1'b0);
    chk("idle_busy", data_out[30], 1'b0);

    // MAX_DIM=4 instance: oversize command errors, next command runs
    tgt4 = 1'b1;
    start_cmd(3, 2);
    chk("err4", data_out4[29], 1'b1);
    chk("busy4_err", data_out4[30], 1'b0);
    repeat (3) tick();
    chk("cs4_none", cs_cnt4, 0);
    start_cmd(1, 2);
    chk("err4_clr", data_out4[29], 1'b0);
    chk("busy4_recv", data_out4[30], 1'b1);
    load(3, 4, 9, 1, 5);
    repeat (3) tick();
    chk("cs4_one", cs_cnt4, 1);
    fill_done(3, 4, 11);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
